pci_intr_ctrl: RTL and testbench

//   AXI4-Lite register slave hung off the PCI target's tgt_m_* port.

---
 rtl/pci_intr_pkg.sv | 40 ++++
 rtl/pci_intr_throttle.sv | 69 ++++++
 rtl/pci_intr_ctrl.sv | 148 ++++++++++++++
 tb/tb_pci_intr_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_intr_pkg.sv
// Shared definitions for the PCI interrupt controller: register indices,
// throttle FSM states, response codes and the write-request payload.
package pci_intr_pkg;

    localparam int unsigned ADDR_IDX_W = 3;
    localparam int unsigned ITR_W      = 16;
    localparam int unsigned DATA_W     = 32;

    // Register indices as decoded from address bits [4:2]
    localparam logic [ADDR_IDX_W-1:0] REG_ICR = 3'd0;
    localparam logic [ADDR_IDX_W-1:0] REG_ICS = 3'd1;
    localparam logic [ADDR_IDX_W-1:0] REG_IMS = 3'd2;
    localparam logic [ADDR_IDX_W-1:0] REG_IMC = 3'd3;
    localparam logic [ADDR_IDX_W-1:0] REG_ITR = 3'd4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } thr_state_e;

    typedef struct packed {
        logic [ADDR_IDX_W-1:0] idx;
        logic [DATA_W-1:0]     bits;
        logic [3:0]            strb;
    } wr_req_t;

    // Expand byte strobes into a per-bit enable mask
    function automatic logic [DATA_W-1:0] strb_to_mask(input logic [3:0] strb);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/pci_intr_throttle.sv
// Interrupt rate limiter: turns the pending level into intr_request with a
// programmable hold-off between successive assertions.
module pci_intr_throttle
    import pci_intr_pkg::*;
#(
    parameter int unsigned ITR_SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pending,
    input  logic [ITR_W-1:0] itr,
    output logic             intr_request
);

    localparam int unsigned CNT_W = ITR_W + ITR_SHIFT;

    thr_state_e       state;
    thr_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             req_next;

    // Next-state, hold-off counter and request level
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_next   = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_next = ASSERT;
                end
            end
            ASSERT: begin
                if (!pending) begin
                    if (itr == '0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next   = CNT_W'(itr) << ITR_SHIFT;
                        state_next = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        req_next = (state_next == ASSERT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            intr_request <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            intr_request <= req_next;
        end
    end

endmodule

// File: rtl/pci_intr_ctrl.sv
// AXI4-Lite interrupt cause/mask register block feeding a throttled level
// interrupt request toward the PCI top.
module pci_intr_ctrl
    import pci_intr_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = 16,
    parameter int unsigned ITR_SHIFT  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [31:0]           s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic                  intr_request
);

    logic [NUM_EVENTS-1:0] cause;
    logic [NUM_EVENTS-1:0] mask;
    logic [ITR_W-1:0]      itr;

    logic                  wr_hs;
    logic                  rd_hs;
    wr_req_t               wr_req;
    logic [ADDR_IDX_W-1:0] rd_idx;

    logic [NUM_EVENTS-1:0] w1c;
    logic [NUM_EVENTS-1:0] ics_set;
    logic [NUM_EVENTS-1:0] ims_set;
    logic [NUM_EVENTS-1:0] imc_clr;
    logic [NUM_EVENTS-1:0] rd_clr;
    logic [ITR_W-1:0]      itr_next;
    logic [31:0]           rd_word;
    logic [NUM_EVENTS-1:0] cause_next;
    logic [NUM_EVENTS-1:0] mask_next;
    logic                  pending;
    logic                  unused_bits;

    assign s_bresp = RESP_OKAY;
    assign s_rresp = RESP_OKAY;

    assign wr_hs = s_awready & s_awvalid & s_wvalid;
    assign rd_hs = s_arready & s_arvalid;

    assign wr_req.idx  = s_awaddr[4:2];
    assign wr_req.bits = s_wdata & strb_to_mask(s_wstrb);
    assign wr_req.strb = s_wstrb;
    assign rd_idx      = s_araddr[4:2];

    // Register write decode, read mux and clear-on-read
    always_comb begin
        w1c      = '0;
        ics_set  = '0;
        ims_set  = '0;
        imc_clr  = '0;
        rd_clr   = '0;
        itr_next = itr;
        rd_word  = '0;
        if (wr_hs) begin
            case (wr_req.idx)
                REG_ICR: w1c     = wr_req.bits[NUM_EVENTS-1:0];
                REG_ICS: ics_set = wr_req.bits[NUM_EVENTS-1:0];
                REG_IMS: ims_set = wr_req.bits[NUM_EVENTS-1:0];
                REG_IMC: imc_clr = wr_req.bits[NUM_EVENTS-1:0];
                REG_ITR: begin
                    if (wr_req.strb[0]) itr_next[7:0]  = wr_req.bits[7:0];
                    if (wr_req.strb[1]) itr_next[15:8] = wr_req.bits[15:8];
                end
                default: ;
            endcase
        end
        case (rd_idx)
            REG_ICR: rd_word = 32'(cause);
            REG_IMS: rd_word = 32'(mask);
            REG_ITR: rd_word = 32'(itr);
            default: rd_word = '0;
        endcase
        if (rd_hs && (rd_idx == REG_ICR)) begin
            rd_clr = cause;
        end
    end

    // Sets win over clears so an event in a clearing cycle survives
    assign cause_next = (cause & ~rd_clr & ~w1c) | ics_set | event_i;
    assign mask_next  = (mask | ims_set) & ~imc_clr;
    assign pending    = |(cause & mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            cause     <= '0;
            mask      <= '0;
            itr       <= '0;
        end else begin
            s_awready <= !s_awready && s_awvalid && s_wvalid && !s_bvalid;
            s_wready  <= !s_awready && s_awvalid && s_wvalid && !s_bvalid;
            if (wr_hs) begin
                s_bvalid <= 1'b1;
            end else if (s_bready) begin
                s_bvalid <= 1'b0;
            end
            s_arready <= !s_arready && s_arvalid && !s_rvalid;
            if (rd_hs) begin
                s_rvalid <= 1'b1;
                s_rdata  <= rd_word;
            end else if (s_rready) begin
                s_rvalid <= 1'b0;
            end
            cause <= cause_next;
            mask  <= mask_next;
            itr   <= itr_next;
        end
    end

    pci_intr_throttle #(
        .ITR_SHIFT (ITR_SHIFT)
    ) u_throttle (
        .clk          (clk),
        .rst          (rst),
        .pending      (pending),
        .itr          (itr),
        .intr_request (intr_request)
    );

    // Undecoded address bits and data bits above the event width
    assign unused_bits = ^{s_awaddr[31:5], s_awaddr[1:0],
                           s_araddr[31:5], s_araddr[1:0], wr_req.bits};

endmodule

// File: tb/tb_pci_intr_ctrl.sv
// Self-checking bench for pci_intr_ctrl: directed scenarios plus randomized
// register traffic checked against an abstract register/interrupt model.
module tb_pci_intr_ctrl;

    localparam int unsigned NE = 16;
    localparam int unsigned SH = 8;
    localparam logic [31:0] EV_MASK = (NE == 32) ? 32'hFFFF_FFFF : ((32'd1 << NE) - 32'd1);
    localparam logic [31:0] A_ICR = 32'h00;
    localparam logic [31:0] A_ICS = 32'h04;
    localparam logic [31:0] A_IMS = 32'h08;
    localparam logic [31:0] A_IMC = 32'h0C;
    localparam logic [31:0] A_ITR = 32'h10;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   s_awaddr;
    logic          s_awvalid;
    logic          s_awready;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic          s_wvalid;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready;
    logic [31:0]   s_araddr;
    logic          s_arvalid;
    logic          s_arready;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready;
    logic [NE-1:0] event_i;
    logic          intr_request;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_cause;
    logic [31:0] m_mask;
    logic [31:0] m_itr;

    always #5 clk = ~clk;

    pci_intr_ctrl #(.NUM_EVENTS(NE), .ITR_SHIFT(SH)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_awaddr     (s_awaddr),
        .s_awvalid    (s_awvalid),
        .s_awready    (s_awready),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_bresp      (s_bresp),
        .s_bvalid     (s_bvalid),
        .s_bready     (s_bready),
        .s_araddr     (s_araddr),
        .s_arvalid    (s_arvalid),
        .s_arready    (s_arready),
        .s_rdata      (s_rdata),
        .s_rresp      (s_rresp),
        .s_rvalid     (s_rvalid),
        .s_rready     (s_rready),
        .event_i      (event_i),
        .intr_request (intr_request)
    );

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        case ((addr >> 2) & 32'd7)
            32'd0:   return m_cause;
            32'd2:   return m_mask;
            32'd4:   return m_itr;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] d;
        d = data & byte_mask(strb);
        case ((addr >> 2) & 32'd7)
            32'd0: m_cause = m_cause & ~(d & EV_MASK);
            32'd1: m_cause = m_cause | (d & EV_MASK);
            32'd2: m_mask  = m_mask | (d & EV_MASK);
            32'd3: m_mask  = m_mask & ~(d & EV_MASK);
            32'd4: m_itr   = (m_itr & ~(byte_mask(strb) & 32'hFFFF)) | (d & 32'hFFFF);
            default: ;
        endcase
    endtask

    function automatic logic exp_intr();
        return (m_cause & m_mask) != 32'd0;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit got;
        @(posedge clk); #1;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_awready) begin got = 1; break; end
        end
        checks++;
        if (!got || s_wready !== 1'b1) begin
            errors++;
            $display("FAIL write_accept addr=%h: awready=%b wready=%b, required both 1", addr, s_awready, s_wready);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            return;
        end
        @(posedge clk);
        model_write(addr, data, strb);
        #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
            errors++;
            $display("FAIL write_resp addr=%h: bvalid=%b bresp=%b, required 1/00", addr, s_bvalid, s_bresp);
        end
        for (int i = 0; i < 20; i++) begin
            if (!s_bvalid) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [NE-1:0] ev, output logic [31:0] data);
        bit got;
        logic [31:0] exp;
        @(posedge clk); #1;
        s_araddr = addr; s_arvalid = 1'b1;
        got = 0;
        data = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_arready) begin got = 1; break; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL read_accept addr=%h: arready never rose", addr);
            s_arvalid = 1'b0;
            return;
        end
        event_i = ev;
        exp = model_read(addr);
        @(posedge clk);
        if (((addr >> 2) & 32'd7) == 32'd0) m_cause = 32'd0;
        m_cause = m_cause | 32'(ev);
        #1;
        s_arvalid = 1'b0; event_i = '0;
        data = s_rdata;
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== exp || s_rresp !== 2'b00) begin
            errors++;
            $display("FAIL read_data addr=%h: rvalid=%b rdata=%h rresp=%b, required 1/%h/00",
                     addr, s_rvalid, s_rdata, s_rresp, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_event(input logic [NE-1:0] ev);
        @(posedge clk); #1;
        event_i = ev;
        @(posedge clk);
        m_cause = m_cause | 32'(ev);
        #1;
        event_i = '0;
    endtask

    task automatic check_intr(input string name, input logic exp);
        checks++;
        if (intr_request !== exp) begin
            errors++;
            $display("FAIL %s: intr_request=%b, required %b", name, intr_request, exp);
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, intr_request} !== 6'b0 || s_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: aw=%b w=%b b=%b ar=%b r=%b intr=%b rdata=%h, required all 0",
                     s_awready, s_wready, s_bvalid, s_arready, s_rvalid, intr_request, s_rdata);
        end
        rst = 1'b0;
        m_cause = '0; m_mask = '0; m_itr = '0;
        @(posedge clk); #1;
        check_intr("reset_intr", 1'b0);
        axi_read(A_ICR, '0, rd);
        axi_read(A_IMS, '0, rd);
        axi_read(A_ITR, '0, rd);
    endtask

    task automatic test_basic;
        logic [31:0] rd;
        axi_write(A_IMS, 32'h1, 4'hF);
        @(posedge clk); #1;
        event_i = 16'h0001;
        @(posedge clk);
        m_cause = m_cause | 32'h1;
        #1;
        event_i = '0;
        check_intr("basic_latch_cycle", 1'b0);
        @(posedge clk); #1;
        check_intr("basic_assert", 1'b1);
        axi_read(A_ICR, '0, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL basic_icr_read: rdata=%h, required 00000001", rd);
        end
        check_intr("basic_deassert", 1'b0);
        axi_read(A_ICR, '0, rd);
        axi_write(A_IMC, 32'hFFFF_FFFF, 4'hF);
    endtask

    task automatic test_mask;
        logic [31:0] rd;
        bit seen;
        pulse_event(16'h0008);
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (intr_request !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mask_blocks: intr_request rose with mask 0, required 0");
        end
        axi_write(A_IMS, 32'h8, 4'hF);
        check_intr("mask_enable", 1'b1);
        axi_read(A_ICR, '0, rd);
        checks++;
        if (rd !== 32'h8) begin
            errors++;
            $display("FAIL mask_icr: rdata=%h, required 00000008", rd);
        end
        check_intr("mask_cleared", 1'b0);
        axi_write(A_IMC, 32'hFFFF_FFFF, 4'hF);
    endtask

    task automatic test_throttle;
        logic [31:0] rd;
        int lows;
        axi_write(A_ITR, 32'h2, 4'hF);
        axi_write(A_IMS, 32'h1, 4'hF);
        pulse_event(16'h0001);
        @(posedge clk); #1;
        check_intr("thr_first_assert", 1'b1);
        axi_read(A_ICR, '0, rd);
        check_intr("thr_drop", 1'b0);
        event_i = 16'h0001;
        lows = 1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (i == 0) m_cause = m_cause | 32'h1;
            #1;
            event_i = '0;
            if (intr_request) break;
            lows++;
        end
        // Hold-off of ITR<<ITR_SHIFT cycles plus the IDLE cycle before re-assert
        checks++;
        if (lows != (2 << SH) + 1) begin
            errors++;
            $display("FAIL thr_holdoff_len: low for %0d cycles, required %0d", lows, (2 << SH) + 1);
        end
        axi_write(A_IMC, 32'hFFFF_FFFF, 4'hF);
        axi_write(A_ITR, 32'h0, 4'hF);
        repeat (600) @(posedge clk);
        axi_write(A_ICR, 32'hFFFF_FFFF, 4'hF);
        check_intr("thr_quiet", 1'b0);
    endtask

    task automatic test_read_collision;
        logic [31:0] rd;
        axi_write(A_ICS, 32'h4, 4'hF);
        axi_read(A_ICR, 16'h0002, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL collide_old: rdata=%h, required 00000004", rd);
        end
        axi_read(A_ICR, '0, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL collide_kept: rdata=%h, required 00000002", rd);
        end
    endtask

    task automatic test_aw_early;
        logic [31:0] rd;
        int accepts;
        bit got;
        bit bad;
        accepts = 0;
        @(posedge clk); #1;
        s_bready = 1'b0;
        s_awaddr = A_ICS; s_wdata = 32'h10; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (s_awready) accepts++;
        end
        @(posedge clk); #1;
        s_wvalid = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_awready) begin accepts++; got = 1; break; end
        end
        @(posedge clk);
        if (got) model_write(A_ICS, 32'h10, 4'hF);
        #1;
        s_wdata = 32'h20;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_bvalid !== 1'b1) bad = 1;
            if (s_awready) begin accepts++; bad = 1; end
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bvalid_hold: bvalid=%b awready=%b while bready low, required 1/0", s_bvalid, s_awready);
        end
        @(posedge clk); #1;
        s_bready = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_awready) begin accepts++; got = 1; break; end
        end
        @(posedge clk);
        if (got) model_write(A_ICS, 32'h20, 4'hF);
        #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (accepts != 2 || s_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL aw_early_accepts: accepts=%0d bvalid=%b, required 2/0", accepts, s_bvalid);
        end
        axi_read(A_ICR, '0, rd);
        checks++;
        if (rd !== 32'h30) begin
            errors++;
            $display("FAIL aw_early_cause: rdata=%h, required 00000030", rd);
        end
    endtask

    task automatic test_strobe;
        logic [31:0] rd;
        axi_write(A_ITR, 32'hFFFF, 4'b0001);
        axi_read(A_ITR, '0, rd);
        checks++;
        if (rd !== 32'h00FF) begin
            errors++;
            $display("FAIL itr_strobe: rdata=%h, required 000000ff", rd);
        end
        axi_read(32'h1C, '0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read: rdata=%h, required 00000000", rd);
        end
        axi_write(A_ITR, 32'h0, 4'hF);
    endtask

    task automatic test_random;
        logic [31:0] rd;
        logic [31:0] addr;
        logic [NE-1:0] ev;
        int unsigned op;
        int unsigned idx;
        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 2);
            idx = $urandom_range(0, 7);
            ev = ($urandom_range(0, 3) == 0) ? NE'($urandom) : '0;
            case (op)
                0: begin
                    if (idx == 4) idx = 5;
                    addr = 32'(idx << 2);
                    axi_write(addr, $urandom, 4'($urandom_range(0, 15)));
                end
                1: begin
                    addr = 32'(idx << 2);
                    axi_read(addr, ev, rd);
                end
                default: pulse_event(NE'($urandom) & NE'($urandom));
            endcase
            @(posedge clk); #1;
            check_intr("random_intr", exp_intr());
        end
    endtask

    initial begin
        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b1; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b1;
        event_i = '0;
        m_cause = '0; m_mask = '0; m_itr = '0;
        test_reset();
        test_basic();
        test_mask();
        test_throttle();
        test_read_collision();
        test_aw_early();
        test_strobe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
